// File: rtl/data_sampler_nx.sv
// Oversampling bit-decision unit for the UART receiver: majority vote over a
// configurable window of samples centred on mid-bit, with valid strobe and noise flag.
module data_sampler_nx #(
    parameter int unsigned PRESCALE_W  = 6,
    parameter int unsigned SAMPLES     = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  en_sampler,
    output logic                  data_sync,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err
);

    localparam int unsigned HALF = SAMPLES / 2;
    localparam int unsigned OW   = $clog2(SAMPLES + 1);
    localparam int unsigned WW   = PRESCALE_W + 1;

    if (!(SAMPLES == 1 || SAMPLES == 3 || SAMPLES == 5 || SAMPLES == 7)) begin : g_bad_samples
        $error("data_sampler_nx: SAMPLES must be 1, 3, 5 or 7");
    end
    if (!(SYNC_STAGES == 0 || SYNC_STAGES == 2 || SYNC_STAGES == 3)) begin : g_bad_sync
        $error("data_sampler_nx: SYNC_STAGES must be 0, 2 or 3");
    end

    // Input synchroniser; flops reset to the idle-high line level
    if (SYNC_STAGES == 0) begin : g_bypass
        assign data_sync = data_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
            end
        end
        assign data_sync = sync_q[SYNC_STAGES-1];
    end

    // Window bounds, one bit wider than prescale so nothing wraps
    logic [WW-1:0] ps_ext;
    logic [WW-1:0] edge_ext;
    logic [WW-1:0] win_start;
    logic [WW-1:0] win_last;
    logic          ps_legal;

    assign ps_ext    = {1'b0, prescale};
    assign edge_ext  = {1'b0, edge_cnt};
    assign win_start = (ps_ext >> 1) - WW'(HALF);
    assign win_last  = win_start + WW'(SAMPLES - 1);
    assign ps_legal  = (ps_ext >= WW'(2 * SAMPLES)) && !prescale[0];

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [OW-1:0] ones;
    logic [OW-1:0] ones_nxt;
    logic [OW-1:0] ones_sum;
    logic [OW-1:0] ones_final;
    logic          fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ones  <= '0;
        end else begin
            state <= state_nxt;
            ones  <= ones_nxt;
        end
    end

    // Window sequencing; a hit on START always reloads, which also covers FSM resync
    always_comb begin
        state_nxt  = state;
        ones_nxt   = ones;
        fire       = 1'b0;
        ones_sum   = ones + OW'(data_sync);
        ones_final = ones_sum;
        if (!en_sampler || !ps_legal) begin
            state_nxt = IDLE;
            ones_nxt  = '0;
        end else if (edge_ext == win_start) begin
            ones_nxt   = OW'(data_sync);
            ones_final = OW'(data_sync);
            if (win_start == win_last) begin
                fire      = 1'b1;
                state_nxt = IDLE;
                ones_nxt  = '0;
            end else begin
                state_nxt = ACC;
            end
        end else if (state == ACC && edge_ext > win_start && edge_ext <= win_last) begin
            ones_nxt = ones_sum;
            if (edge_ext == win_last) begin
                fire      = 1'b1;
                state_nxt = IDLE;
                ones_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            noise_err    <= 1'b0;
        end else begin
            sample_valid <= fire;
            if (fire) begin
                sampled_bit <= (ones_final > OW'(HALF));
                noise_err   <= (ones_final != '0) && (ones_final != OW'(SAMPLES));
            end
        end
    end

endmodule

// File: tb/tb_data_sampler_nx.sv
// Directed bench for data_sampler_nx: three instances cover 3-, 5- and 1-sample
// configurations with and without the input synchroniser.
module tb_data_sampler_nx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_a = 1'b1;
    logic       din_b = 1'b1;
    logic       en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [5:0] edge_cnt = 6'd0;

    logic ds_a, bit_a, v_a, ne_a;
    logic ds_b, bit_b, v_b, ne_b;
    logic ds_c, bit_c, v_c, ne_c;

    int n_chk = 0;
    int n_fail = 0;
    int vn_a, vn_b, vn_c;
    int vp_a, vp_b, vp_c;

    always #5 clk = ~clk;

    data_sampler_nx #(.PRESCALE_W(6), .SAMPLES(3), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .data_in(din_a), .prescale(prescale), .edge_cnt(edge_cnt),
        .en_sampler(en), .data_sync(ds_a), .sampled_bit(bit_a), .sample_valid(v_a),
        .noise_err(ne_a)
    );
    data_sampler_nx #(.PRESCALE_W(6), .SAMPLES(5), .SYNC_STAGES(0)) u_b (
        .clk(clk), .rst(rst), .data_in(din_b), .prescale(prescale), .edge_cnt(edge_cnt),
        .en_sampler(en), .data_sync(ds_b), .sampled_bit(bit_b), .sample_valid(v_b),
        .noise_err(ne_b)
    );
    data_sampler_nx #(.PRESCALE_W(6), .SAMPLES(1), .SYNC_STAGES(0)) u_c (
        .clk(clk), .rst(rst), .data_in(din_b), .prescale(prescale), .edge_cnt(edge_cnt),
        .en_sampler(en), .data_sync(ds_c), .sampled_bit(bit_c), .sample_valid(v_c),
        .noise_err(ne_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        vn_a = 0; vn_b = 0; vn_c = 0;
        vp_a = -1; vp_b = -1; vp_c = -1;
    endtask

    // One clock with the given edge position and line levels; outputs read 1ns after the edge
    task automatic cyc(input int e, input logic a, input logic b, input logic en_v);
        edge_cnt = 6'(e);
        din_a = a;
        din_b = b;
        en = en_v;
        @(posedge clk);
        #1;
        if (v_a) begin vn_a++; vp_a = e; end
        if (v_b) begin vn_b++; vp_b = e; end
        if (v_c) begin vn_c++; vp_c = e; end
    endtask

    // One full bit period; pat[e] drives the unsynchronised line, en drops from edge en_off
    task automatic run_bit(input int ps, input logic a, input logic [15:0] pat, input int en_off);
        prescale = 6'(ps);
        for (int e = 0; e < ps; e++) begin
            cyc(e, a, pat[e[3:0]], e < en_off);
        end
    endtask

    initial begin
        clr();
        // Reset values, synchroniser held high even with the pin low
        din_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ds_a", 32'(ds_a), 32'd1);
        check("rst_bit_a", 32'(bit_a), 32'd1);
        check("rst_valid_a", 32'(v_a), 32'd0);
        check("rst_noise_b", 32'(ne_b), 32'd0);
        check("rst_bit_b", 32'(bit_b), 32'd1);
        rst = 1'b1;

        // Synchroniser: two-clock delay of a 1->0 step
        repeat (3) cyc(0, 1'b1, 1'b1, 1'b0);
        check("sync_pre", 32'(ds_a), 32'd1);
        cyc(0, 1'b0, 1'b1, 1'b0);
        check("sync_1clk", 32'(ds_a), 32'd1);
        cyc(0, 1'b0, 1'b1, 1'b0);
        check("sync_2clk", 32'(ds_a), 32'd0);
        check("sync_no_valid", 32'(vn_a), 32'd0);

        // 3 samples, prescale 8, line low: decision after edge 5
        clr();
        run_bit(8, 1'b0, 16'h0000, 8);
        check("s3_vcount", 32'(vn_a), 32'd1);
        check("s3_vpos", 32'(vp_a), 32'd5);
        check("s3_bit", 32'(bit_a), 32'd0);
        check("s3_noise", 32'(ne_a), 32'd0);
        check("s5_illegal_ps8", 32'(vn_b), 32'd0);

        // Single sample at edge 4, glitches on 3 and 5 ignored
        clr();
        run_bit(8, 1'b0, 16'h0010, 8);
        check("s1_vcount", 32'(vn_c), 32'd1);
        check("s1_vpos", 32'(vp_c), 32'd4);
        check("s1_bit_hi", 32'(bit_c), 32'd1);
        check("s1_noise", 32'(ne_c), 32'd0);
        run_bit(8, 1'b0, 16'h0028, 8);
        check("s1_bit_glitch", 32'(bit_c), 32'd0);

        // Enable dropped mid-window: no decision, bit holds; next bit decides normally
        run_bit(8, 1'b1, 16'h0000, 8);
        check("en_pre_bit", 32'(bit_a), 32'd1);
        clr();
        run_bit(8, 1'b0, 16'h0000, 4);
        check("en_drop_vcount", 32'(vn_a), 32'd0);
        check("en_drop_hold", 32'(bit_a), 32'd1);
        clr();
        run_bit(8, 1'b0, 16'h0000, 8);
        check("en_restore_vcount", 32'(vn_a), 32'd1);
        check("en_restore_vpos", 32'(vp_a), 32'd5);
        check("en_restore_bit", 32'(bit_a), 32'd0);

        // Illegal prescales inhibit sampling
        clr();
        repeat (3) run_bit(4, 1'b1, 16'h0000, 4);
        check("ps4_vcount", 32'(vn_a), 32'd0);
        check("ps4_hold", 32'(bit_a), 32'd0);
        clr();
        repeat (3) run_bit(7, 1'b1, 16'h0000, 7);
        check("ps7_vcount", 32'(vn_a), 32'd0);
        check("ps7_hold", 32'(bit_a), 32'd0);

        // FSM resync: edge_cnt jumps back to START, accumulation reloads
        prescale = 6'd16;
        clr();
        for (int e = 0; e <= 8; e++) cyc(e, 1'b0, 1'b1, 1'b1);
        for (int e = 6; e <= 15; e++) cyc(e, 1'b0, 1'b0, 1'b1);
        check("resync_vcount", 32'(vn_b), 32'd1);
        check("resync_vpos", 32'(vp_b), 32'd10);
        check("resync_bit", 32'(bit_b), 32'd0);
        check("resync_noise", 32'(ne_b), 32'd0);

        // Disable coincident with LAST wins
        clr();
        for (int e = 0; e <= 9; e++) cyc(e, 1'b0, 1'b1, 1'b1);
        for (int e = 10; e <= 15; e++) cyc(e, 1'b0, 1'b1, 1'b0);
        check("dis_last_vcount", 32'(vn_b), 32'd0);
        check("dis_last_hold", 32'(bit_b), 32'd0);

        // 5 samples at edges 6..10
        clr();
        run_bit(16, 1'b0, 16'h07C0, 16);
        check("s5_all1_vpos", 32'(vp_b), 32'd10);
        check("s5_all1_bit", 32'(bit_b), 32'd1);
        check("s5_all1_noise", 32'(ne_b), 32'd0);
        run_bit(16, 1'b0, 16'h02C0, 16);
        check("s5_3ones_bit", 32'(bit_b), 32'd1);
        check("s5_3ones_noise", 32'(ne_b), 32'd1);
        clr();
        run_bit(16, 1'b0, 16'hFA7F, 16);
        check("s5_2ones_vcount", 32'(vn_b), 32'd1);
        check("s5_2ones_bit", 32'(bit_b), 32'd0);
        check("s5_2ones_noise", 32'(ne_b), 32'd1);

        // Asynchronous reset mid-window
        for (int e = 0; e <= 7; e++) cyc(e, 1'b0, 1'b0, 1'b1);
        check("prerst_bit_a", 32'(bit_a), 32'd0);
        check("prerst_ds_a", 32'(ds_a), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_bit_a", 32'(bit_a), 32'd1);
        check("arst_ds_a", 32'(ds_a), 32'd1);
        check("arst_bit_b", 32'(bit_b), 32'd1);
        check("arst_noise_b", 32'(ne_b), 32'd0);
        check("arst_valid_b", 32'(v_b), 32'd0);
        #2 rst = 1'b1;
        cyc(0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sampler_nx.md
Name: data_sampler_nx

Overview:
- Parametrised oversampling bit-decision unit for the UART receiver. It is the successor to the fixed 3-sample majority sampler.
- Adds a configurable sample count (1/3/5/7) centred on mid-bit and an optional input synchroniser.
- Adds a one-cycle decision-valid strobe and a noise flag raised when the samples disagree.
- Sits between the rx pin and the receiver FSM/deserialiser, driven by the FSM's edge counter.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_cnt; supports oversampling up to 2^PRESCALE_W-1.
- SAMPLES, 3, samples per bit; legal values 1, 3, 5, 7. Any other value is an elaboration error.
- SYNC_STAGES, 2, flops in the data_in synchroniser; 0 = bypass, otherwise 2 or 3.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- data_in  input  1  raw serial line (idle high)
- prescale  input  PRESCALE_W  oversampling ratio; even, static while en_sampler=1
- edge_cnt  input  PRESCALE_W  position within the current bit, 0..prescale-1, from the FSM edge counter
- en_sampler  input  1  sampling enable from the FSM
- data_sync  output  1  synchronised line; the FSM uses this for start-edge detection
- sampled_bit  output  1  registered majority decision, held between decisions
- sample_valid  output  1  one-cycle pulse when sampled_bit updates
- noise_err  output  1  registered with sample_valid; 1 if the samples of that bit disagreed

Behaviour:
- Reset (rst=0, async):
  - synchroniser flops = 1, sampled_bit = 1, sample_valid = 0, noise_err = 0.
  - ones counter = 0, window state = IDLE.
- Synchroniser: data_sync = data_in delayed SYNC_STAGES clk. With SYNC_STAGES=0, data_sync = data_in combinationally. All sampling uses data_sync.
- Window:
  - HALF = SAMPLES/2 (integer). START = prescale/2 - HALF. LAST = START + SAMPLES - 1.
  - Computed at PRESCALE_W+1 bits, so no wrap.
- Legality: prescale is legal when prescale >= 2*SAMPLES and prescale[0] = 0. An illegal prescale inhibits sampling entirely: no sample_valid, outputs hold.
- States:
  - IDLE -> ACC when en_sampler=1 and edge_cnt==START. On that cycle ones <= data_sync; the first sample loads, it does not accumulate.
  - ACC: ones <= ones + data_sync on each cycle where edge_cnt is in (START, LAST]. Cycles outside the window do not change ones.
  - ACC -> IDLE on the cycle edge_cnt==LAST, after that sample is included. The cycle after, sampled_bit and noise_err are registered and sample_valid=1 for exactly one cycle.
  - When SAMPLES=1, START==LAST: the decision follows the single sample at the next cycle.
- Decision rules:
  - sampled_bit = (ones_final > HALF).
  - noise_err = (ones_final != 0) && (ones_final != SAMPLES).
  - ones is $clog2(SAMPLES+1) bits wide and cannot overflow.
- Latency: sample_valid asserts 1 clk after edge_cnt==LAST. Total pin-to-decision delay = SYNC_STAGES + (LAST - edge of interest) + 1 clk.
- en_sampler deasserted at any time: return to IDLE, clear ones, no sample_valid. sampled_bit and noise_err hold their last values.
- en_sampler re-asserted mid-window (edge_cnt > START): no decision for that bit. Sampling resumes at the next START.
- edge_cnt jumping backwards to START while in ACC (FSM resync): restart accumulation (load, not add). No sample_valid for the aborted window.
- Simultaneous en_sampler fall and edge_cnt==LAST: the disable wins and no sample_valid is issued.
- Reset mid-window: immediate return to reset values. The previously valid decision is lost.
- sampled_bit changes only on a sample_valid cycle.

Test Plan:
- SAMPLES=3, prescale=8, data_in held 0 for a full bit: samples at edge_cnt 3,4,5; sample_valid 1 clk after edge_cnt=5; sampled_bit=0, noise_err=0.
- SAMPLES=5, prescale=16, data_sync=1 at edge_cnt 6,7,9 and 0 at 8,10 -> sampled_bit=1, noise_err=1. Repeat with 2 ones -> sampled_bit=0, noise_err=1.
- SAMPLES=1, prescale=8: single sample at edge_cnt=4. Glitch at edge_cnt 3 and 5 ignored; sampled_bit equals the value at edge_cnt 4.
- SYNC_STAGES=2: step data_in 1->0 -> data_sync falls exactly 2 clk later. After rst, data_sync=1 and sampled_bit=1 with no sample_valid.
- SAMPLES=3, prescale=8: drop en_sampler at edge_cnt=4 -> no sample_valid, sampled_bit holds. Restore at edge_cnt=0 of the next bit -> normal decision.
- Illegal prescale=4 with SAMPLES=3, and prescale=7 -> sample_valid stays 0 over 3 bit periods. Assert rst mid-window at prescale=16 -> outputs go to reset values asynchronously.
